// File: rtl/demosaic_window_ctrl_pkg.sv
// Shared types and constants for the demosaic window sequencer.
package demosaic_window_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // CFA phase of pixel (0,0)
  localparam logic [1:0] CFA_RGGB = 2'b00;
  localparam logic [1:0] CFA_GRBG = 2'b01;
  localparam logic [1:0] CFA_GBRG = 2'b10;
  localparam logic [1:0] CFA_BGGR = 2'b11;

  localparam int PIX_W = 10;

  // CFA phase of a pixel from the parity of its coordinates
  function automatic logic [1:0] cfa_phase(input logic row_lsb, input logic col_lsb,
                                           input logic [1:0] pat);
    return {row_lsb, col_lsb} ^ pat;
  endfunction

endpackage

// File: rtl/demosaic_window_ctrl_if.sv
// Stream handshake plus window-datapath control bundle of the sequencer.
interface demosaic_window_ctrl_if #(
  parameter int CW = 10,
  parameter int RW = 9
);
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic          shift_en;
  logic [CW-1:0] lb_addr;
  logic          lb_wr_en;
  logic          pad;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic [3:0]    edge_tblr;
  logic [1:0]    bayer_phase;

  // Sequencer side
  modport master (
    input  in_valid, out_ready,
    output in_ready, out_valid, shift_en, lb_addr, lb_wr_en, pad,
           win_row, win_col, edge_tblr, bayer_phase
  );

  // Stream source / window consumer side
  modport slave (
    output in_valid, out_ready,
    input  in_ready, out_valid, shift_en, lb_addr, lb_wr_en, pad,
           win_row, win_col, edge_tblr, bayer_phase
  );
endinterface

// File: rtl/demosaic_window_ctrl_pos_counter.sv
// Raster position counter: column wraps into row, row saturates at the last line.
module demosaic_window_ctrl_pos_counter #(
  parameter int W  = 640,
  parameter int H  = 480,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_col,
  output logic          last_pix
);

  assign last_col = (col == CW'(W - 1));
  assign last_pix = last_col & (row == RW'(H - 1));

  // Advance one pixel in raster order; no wrap past the end of the frame
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (last_col) begin
        col <= '0;
        if (row != RW'(H - 1)) row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/demosaic_window_ctrl.sv
// Demosaic 3x3 window sequencer: FSM, handshakes and the window output register stage.
module demosaic_window_ctrl
  import demosaic_window_ctrl_pkg::*;
#(
  parameter int         IMG_W     = 640,
  parameter int         IMG_H     = 480,
  parameter int         CW        = $clog2(IMG_W),
  parameter int         RW        = $clog2(IMG_H),
  parameter logic [1:0] BAYER_PAT = CFA_RGGB
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   frame_done,
  demosaic_window_ctrl_if.master bus
);

  state_t        state, state_nxt;
  logic          in_ready, shift_en, pad;
  logic          in_fire, can_present, emit, frame_start, last_accept;
  logic          out_valid_q, last_emitted_q, frame_done_q;
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;
  logic [CW-1:0] in_col, out_col;
  logic [RW-1:0] in_row, out_row;
  logic          in_last_pix, out_last_pix;
  logic          in_last_col_unused, out_last_col_unused;

  assign in_fire     = bus.in_valid & in_ready;
  assign can_present = ~out_valid_q | bus.out_ready;
  assign frame_start = (state == ST_IDLE) & start;
  // Once the fill is done every shift completes the window of the next centre
  assign emit        = shift_en & ((state == ST_RUN) | (state == ST_FLUSH));
  assign last_accept = (state == ST_FLUSH) & last_emitted_q & out_valid_q & bus.out_ready;

  // Input position; during the flush it keeps stepping as the pad column counter
  demosaic_window_ctrl_pos_counter #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_in_pos (
    .clk(clk), .rst(rst), .clr(frame_start), .inc(shift_en),
    .col(in_col), .row(in_row), .last_col(in_last_col_unused), .last_pix(in_last_pix)
  );

  // Centre position of the next window to be emitted
  demosaic_window_ctrl_pos_counter #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_out_pos (
    .clk(clk), .rst(rst), .clr(frame_start), .inc(emit),
    .col(out_col), .row(out_row), .last_col(out_last_col_unused), .last_pix(out_last_pix)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: fill W+1 pixels, run to the last input, flush to the last window
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FILL;
      ST_FILL:  if (in_fire && in_row == RW'(1) && in_col == '0) state_nxt = ST_RUN;
      ST_RUN:   if (in_fire && in_last_pix) state_nxt = ST_FLUSH;
      ST_FLUSH: if (last_accept) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Per-state handshake and shift control
  always_comb begin
    in_ready = 1'b0;
    shift_en = 1'b0;
    pad      = 1'b0;
    case (state)
      ST_FILL: begin
        in_ready = 1'b1;
        shift_en = bus.in_valid;
      end
      ST_RUN: begin
        in_ready = can_present;
        shift_en = bus.in_valid & can_present;
      end
      ST_FLUSH: begin
        shift_en = ~last_emitted_q & can_present;
        pad      = shift_en;
      end
      default: ;
    endcase
  end

  // Window output register: load tags on emit, hold until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      win_row_q   <= out_row;
      win_col_q   <= out_col;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Frame bookkeeping: stop padding after the last centre, pulse done after its acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      last_emitted_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      if (frame_start)               last_emitted_q <= 1'b0;
      else if (emit && out_last_pix) last_emitted_q <= 1'b1;
      frame_done_q <= last_accept;
    end
  end

  assign busy            = (state != ST_IDLE);
  assign frame_done      = frame_done_q;
  assign bus.in_ready    = in_ready;
  assign bus.shift_en    = shift_en;
  assign bus.pad         = pad;
  assign bus.lb_wr_en    = shift_en & ~pad;
  assign bus.lb_addr     = in_col;
  assign bus.out_valid   = out_valid_q;
  assign bus.win_row     = win_row_q;
  assign bus.win_col     = win_col_q;
  // Tag-derived flags are only driven while a window is presented
  assign bus.edge_tblr   = out_valid_q ? {win_row_q == '0, win_row_q == RW'(IMG_H - 1),
                                          win_col_q == '0, win_col_q == CW'(IMG_W - 1)} : 4'b0000;
  assign bus.bayer_phase = out_valid_q ? cfa_phase(win_row_q[0], win_col_q[0], BAYER_PAT) : 2'b00;

endmodule

// File: tb/tb_demosaic_window_ctrl.sv
// Self-checking bench for demosaic_window_ctrl (4x3 frame, RGGB and GRBG instances).
module tb_demosaic_window_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 2;
  localparam int RW = 2;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } centre_t;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic busy_a, frame_done_a, busy_b, frame_done_b;

  always #5 clk = ~clk;

  demosaic_window_ctrl_if #(.CW(CW), .RW(RW)) ifa ();
  demosaic_window_ctrl_if #(.CW(CW), .RW(RW)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.out_ready = out_ready;

  demosaic_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW), .BAYER_PAT(2'b00)) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a), .frame_done(frame_done_a), .bus(ifa.master)
  );

  demosaic_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW), .BAYER_PAT(2'b01)) dut_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_b), .frame_done(frame_done_b), .bus(ifb.master)
  );

  int      n_cmp = 0;
  int      n_mis = 0;
  centre_t sb[$];
  int      s_cnt = 0;
  int      n_acc = 0;
  int      pad_cnt = 0;
  bit      m_busy = 0;
  bit      m_ov = 0;
  bit      m_fd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        sb.push_back('{row: RW'(r), col: CW'(c)});
  endtask

  // One clock: check outputs at the falling edge against the model, then advance the model
  task automatic cycle();
    bit      eir, esh, fd_next, ov_next, busy_next;
    centre_t e;
    @(negedge clk);
    if (!m_busy)             eir = 1'b0;
    else if (s_cnt < W + 1)  eir = 1'b1;
    else if (s_cnt < W * H)  eir = !m_ov || out_ready;
    else                     eir = 1'b0;
    if (!m_busy)             esh = 1'b0;
    else if (s_cnt < W * H)  esh = in_valid && eir;
    else                     esh = (s_cnt < W * H + W + 1) && (!m_ov || out_ready);

    check("busy", 32'(busy_a), 32'(m_busy));
    check("frame_done", 32'(frame_done_a), 32'(m_fd));
    check("out_valid", 32'(ifa.out_valid), 32'(m_ov));
    check("out_valid_b", 32'(ifb.out_valid), 32'(m_ov));
    check("in_ready", 32'(ifa.in_ready), 32'(eir));
    check("shift_en", 32'(ifa.shift_en), 32'(esh));
    if (esh) begin
      check("lb_addr", 32'(ifa.lb_addr), 32'(s_cnt % W));
      check("pad", 32'(ifa.pad), 32'(s_cnt >= W * H));
      check("lb_wr_en", 32'(ifa.lb_wr_en), 32'(s_cnt < W * H));
    end
    if (ifa.shift_en && ifa.pad) pad_cnt++;

    if (m_ov && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("win_row", 32'(ifa.win_row), 32'(e.row));
        check("win_col", 32'(ifa.win_col), 32'(e.col));
        check("edge_tblr", 32'(ifa.edge_tblr),
              32'({e.row == 0, e.row == RW'(H - 1), e.col == 0, e.col == CW'(W - 1)}));
        check("phase_rggb", 32'(ifa.bayer_phase), 32'({e.row[0], e.col[0]}));
        check("phase_grbg", 32'(ifb.bayer_phase), 32'({e.row[0], e.col[0]} ^ 2'b01));
      end
      n_acc++;
    end

    fd_next   = m_busy && m_ov && out_ready && (n_acc == W * H);
    ov_next   = (esh && s_cnt >= W + 1) ? 1'b1 : (m_ov && !out_ready);
    busy_next = fd_next ? 1'b0 : m_busy;
    if (esh) s_cnt++;
    if (start && !m_busy) begin
      sb.delete();
      push_frame();
      s_cnt     = 0;
      n_acc     = 0;
      pad_cnt   = 0;
      busy_next = 1'b1;
    end
    m_busy = busy_next;
    m_ov   = ov_next;
    m_fd   = fd_next;
    if (rst) begin
      sb.delete();
      s_cnt  = 0;
      n_acc  = 0;
      m_busy = 1'b0;
      m_ov   = 1'b0;
      m_fd   = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // mode 0: streaming, 1: in_valid toggling, 2: random out_ready
  task automatic run_until_idle(input int mode, input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      case (mode)
        1:       begin in_valid = n[0]; out_ready = 1'b1; end
        2:       begin in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1)); end
        default: begin in_valid = 1'b1; out_ready = 1'b1; end
      endcase
      cycle();
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("frame_end_busy", 32'(busy_a), 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);
    check("pad_shifts", 32'(pad_cnt), 32'(W + 1));
  endtask

  task automatic run_until_shifts(input int target, input int budget);
    int n = 0;
    while (s_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    check("shift_budget", 32'(s_cnt), 32'(target));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("reset_state", 32'({ifa.win_row, ifa.win_col, ifa.edge_tblr, ifa.bayer_phase,
                             ifa.lb_addr, ifa.out_valid, busy_a, frame_done_a}), 32'd0);

    // Back-to-back frame
    pulse_start();
    run_until_idle(0, 200);

    // Backpressure hold in RUN
    pulse_start();
    in_valid = 1'b1; out_ready = 1'b1;
    run_until_shifts(8, 50);
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      cycle();
      if (sb.size() > 0) begin
        check("hold_row", 32'(ifa.win_row), 32'(sb[0].row));
        check("hold_col", 32'(ifa.win_col), 32'(sb[0].col));
      end
    end
    run_until_idle(0, 200);

    // Gapped input stream
    pulse_start();
    run_until_idle(1, 300);

    // Flush with in_valid held and random backpressure
    pulse_start();
    run_until_idle(2, 400);

    // Reset on the 8th input, then restart with an ignored mid-frame start
    pulse_start();
    in_valid = 1'b1; out_ready = 1'b1;
    run_until_shifts(7, 50);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    cycle();
    check("rst_mid_outputs", 32'({ifa.win_row, ifa.win_col, ifa.edge_tblr, ifa.bayer_phase,
                                 ifa.lb_addr, ifa.out_valid, ifa.in_ready, ifa.shift_en,
                                 busy_a, frame_done_a}), 32'd0);
    pulse_start();
    in_valid = 1'b1;
    run_until_shifts(3, 20);
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_until_idle(0, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
